// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        DBG_BURST = 1'b1
    } state_t;

    // Write-enable encoding shared by the CPU port and the memory port.
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_BYTE = 2'b11;

endpackage

// File: rtl/dmem_burst_gen.sv
// Debug burst address generator: latches the burst base, counts beats and
// produces the wrapping beat address plus a final-beat flag.
module dmem_burst_gen #(
    parameter int AW        = 10,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          advance,
    input  logic [AW-1:0] base_in,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int BW = $clog2(BURST_LEN + 1);

    logic [AW-1:0] base;
    logic [BW-1:0] beat;

    // Base register and beat counter; beat 0 is issued directly from the
    // request address, so the counter starts at 1.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            beat <= '0;
        end else if (start) begin
            base <= base_in;
            beat <= BW'(1);
        end else if (advance) begin
            beat <= last ? '0 : beat + BW'(1);
        end
    end

    // Address arithmetic wraps naturally modulo 2^AW.
    assign addr = base + AW'(beat);
    assign last = (beat == BW'(BURST_LEN - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store port and the
// debug/display burst reader. Read data is registered one cycle after grant.
// Optional debug aging (forced grant after MAX_WAIT starved cycles) is
// enabled by defining DMEM_ARB_AGING_EN; default build is strict CPU priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_last,
    output logic          busy,
    output logic [DW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [1:0]    mem_we,
    input  logic [DW-1:0] mem_rd
);

    state_t        state, state_next;
    logic [AW-1:0] addr_sel;
    logic [AW-1:0] burst_addr;
    logic          burst_last;
    logic          burst_adv;
    logic          forced;
    logic          cpu_rd_gnt;
    logic          dbg_beat;
    logic          dbg_final;

    dmem_burst_gen #(
        .AW        (AW),
        .BURST_LEN (BURST_LEN)
    ) u_burst_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (dbg_gnt),
        .advance (burst_adv),
        .base_in (dbg_addr),
        .addr    (burst_addr),
        .last    (burst_last)
    );

`ifdef DMEM_ARB_AGING_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;

    // Starvation counter: counts cycles the CPU wins while debug waits,
    // saturating at MAX_WAIT; cleared when debug is finally granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (dbg_gnt) begin
            wait_cnt <= '0;
        end else if (dbg_req && cpu_gnt && (wait_cnt != WW'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign forced = (wait_cnt == WW'(MAX_WAIT));
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign forced          = 1'b0;
`endif

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Grant decision, next state and memory-port mux.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        burst_adv  = 1'b0;
        addr_sel   = '0;
        mem_wd     = '0;
        mem_we     = WE_NONE;
        unique case (state)
            IDLE: begin
                if (cpu_req && !forced) begin
                    cpu_gnt  = 1'b1;
                    addr_sel = cpu_addr;
                    mem_wd   = cpu_wdata;
                    mem_we   = cpu_we;
                end else if (dbg_req) begin
                    dbg_gnt    = 1'b1;
                    addr_sel   = dbg_addr;
                    state_next = (BURST_LEN > 1) ? DBG_BURST : IDLE;
                end
            end
            DBG_BURST: begin
                burst_adv = 1'b1;
                addr_sel  = burst_addr;
                if (burst_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_a      = DW'(addr_sel);
    assign busy       = (state == DBG_BURST);
    assign cpu_rd_gnt = cpu_gnt && (cpu_we == WE_NONE);
    assign dbg_beat   = dbg_gnt || burst_adv;
    assign dbg_final  = (burst_adv && burst_last) || (dbg_gnt && (BURST_LEN == 1));

    // Read-return registers: capture mem_rd on granted reads and pulse the
    // matching valid for one cycle; data holds until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            dbg_last   <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_rd_gnt;
            dbg_rvalid <= dbg_beat;
            dbg_last   <= dbg_final;
            if (cpu_rd_gnt) cpu_rdata <= mem_rd;
            if (dbg_beat)   dbg_rdata <= mem_rd;
        end
    end

endmodule
